rsa_seq_ctrl: RTL
=================

// Module: rsa_seq_ctrl
// PURPOSE
//  Operand-entry and run sequencer for the 8-bit RSA modular-exponentiation core.
//  User keys M, E, N on the DIP switches, confirming each with the enter key; block
//  validates operands, pulses core start, captures the result and drives the io_ctrl
//  select/operand inputs so the 7-seg display shows the result until the next key.
// PARAMETERS
//  WIDTH       8        operand/result width
//  KEY_ACTIVE  1'b0     active level of raw enter key
//  TIMEOUT     4096     max cycles in WAIT before abort (>=2)
// PORTS
//  seq_clk     in   1      system clock, rising edge
//  seq_rst     in   1      reset, synchronous, active-high
//  seq_key     in   1      raw enter key (async, debounced externally)
//  seq_din     in   WIDTH  DIP switch value
//  seq_done    in   1      core done, level, valid only in WAIT
//  seq_result  in   WIDTH  core result, valid while seq_done=1
//  seq_m       out  WIDTH  message register to core
//  seq_e       out  WIDTH  exponent register to core
//  seq_n       out  WIDTH  modulus register to core
//  seq_start   out  1      core start, one-cycle pulse
//  seq_c       out  WIDTH  captured result (to io_ctrl ctrl_c)
//  seq_sel     out  1      result-show select (to io_ctrl ctrl_sel)
//  seq_err     out  1      operand/timeout error flag (LED)
//  seq_state   out  3      current state code (LED)
// BEHAVIOUR
//  Reset: state LOAD_M; seq_m/e/n/c=0, start=0, sel=0, err=0, key sync regs inactive,
//   watchdog=0. Reset mid-operation (any state) aborts immediately; core not notified.
//  Key: 2-FF synchronizer s1->s2, plus s3; key_evt = (s2==KEY_ACTIVE)&&(s3!=KEY_ACTIVE).
//   One event per press regardless of hold time. Operand register written on 3rd
//   rising edge after key reaches active level. key_evt ignored in CHECK/START/WAIT.
//  States (seq_state code):
//   LOAD_M(0): key_evt -> m<=din, err<=0, ->LOAD_E
//   LOAD_E(1): key_evt -> e<=din, ->LOAD_N
//   LOAD_N(2): key_evt -> n<=din, ->CHECK
//   CHECK (3): one cycle; if n<2 or m>=n (unsigned) -> err<=1, ->LOAD_M; else ->START
//   START (4): seq_start=1 this cycle only; watchdog<=0; ->WAIT
//   WAIT  (5): done=1 -> c<=result, ->SHOW; else watchdog+1; watchdog==TIMEOUT-1
//              without done -> err<=1, ->LOAD_M (c unchanged). done and timeout in
//              same cycle: done wins.
//   SHOW  (6): sel=1; key_evt -> sel=0, ->LOAD_M
//  seq_sel is registered: 1 from cycle after WAIT->SHOW edge until cycle after exit.
//  seq_start decoded from state (START), no extra register.
//  seq_done outside WAIT ignored. m/e/n held stable from CHECK through SHOW.
//  seq_c holds last valid result until overwritten; err persists until next M load.
//  Unused state code 7 -> LOAD_M next cycle.
// TESTING
//  1 Reset: assert seq_rst 2 cycles mid-WAIT -> state=0, all outputs 0, start never
//    pulses again until new entry.
//  2 Nominal: keys M=5,E=7,N=143; core model returns 47 after 20 cycles -> one start
//    pulse, seq_c=47, seq_sel=1, state=6; next key -> sel=0, state=0.
//  3 Bad operands: M=200,E=3,N=143 -> err=1, state 0 one cycle after CHECK, no
//    start; N=1 same; next M key clears err.
//  4 Timeout: TIMEOUT=64, core never done -> err=1 and state 0 exactly 64 cycles
//    after START, seq_c unchanged.
//  5 Key hold 500 cycles in LOAD_M -> only m loaded, state=1; key pulses during
//    WAIT -> ignored, operands unchanged.
//  6 done and watchdog expiry same cycle -> seq_c captured, state=6, err=0.

Source files
------------

// File: rtl/rsa_seq_ctrl.sv
// Operand-entry and run sequencer for the 8-bit RSA modexp core.
// Loads M/E/N from the DIP switches, validates them, runs the core, shows the result.
module rsa_seq_ctrl #(
  parameter int   WIDTH      = 8,
  parameter logic KEY_ACTIVE = 1'b0,
  parameter int   TIMEOUT    = 4096
) (
  input  logic             seq_clk,
  input  logic             seq_rst,
  input  logic             seq_key,
  input  logic [WIDTH-1:0] seq_din,
  input  logic             seq_done,
  input  logic [WIDTH-1:0] seq_result,
  output logic [WIDTH-1:0] seq_m,
  output logic [WIDTH-1:0] seq_e,
  output logic [WIDTH-1:0] seq_n,
  output logic             seq_start,
  output logic [WIDTH-1:0] seq_c,
  output logic             seq_sel,
  output logic             seq_err,
  output logic [2:0]       seq_state
);

  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] N_MIN = WIDTH'(2);

  typedef enum logic [2:0] {
    LOAD_M = 3'd0,
    LOAD_E = 3'd1,
    LOAD_N = 3'd2,
    CHECK  = 3'd3,
    START  = 3'd4,
    WAIT   = 3'd5,
    SHOW   = 3'd6
  } state_t;

  state_t           r_state;
  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_e;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_c;
  logic             r_sel;
  logic             r_err;
  logic [WDW-1:0]   r_wd;

  logic w_key_evt;
  logic w_bad_ops;

  // s3 only exists to turn the synchronized level into one event per press
  assign w_key_evt = (r_s2 == KEY_ACTIVE) && (r_s3 != KEY_ACTIVE);
  assign w_bad_ops = (r_n < N_MIN) || (r_m >= r_n);

  always_ff @(posedge seq_clk) begin
    if (seq_rst) begin
      r_s1 <= ~KEY_ACTIVE;
      r_s2 <= ~KEY_ACTIVE;
      r_s3 <= ~KEY_ACTIVE;
    end else begin
      r_s1 <= seq_key;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_ff @(posedge seq_clk) begin
    if (seq_rst) begin
      r_state <= LOAD_M;
      r_m     <= '0;
      r_e     <= '0;
      r_n     <= '0;
      r_c     <= '0;
      r_sel   <= 1'b0;
      r_err   <= 1'b0;
      r_wd    <= '0;
    end else begin
      unique case (r_state)
        LOAD_M: if (w_key_evt) begin
          r_m     <= seq_din;
          r_err   <= 1'b0;
          r_state <= LOAD_E;
        end
        LOAD_E: if (w_key_evt) begin
          r_e     <= seq_din;
          r_state <= LOAD_N;
        end
        LOAD_N: if (w_key_evt) begin
          r_n     <= seq_din;
          r_state <= CHECK;
        end
        CHECK: begin
          if (w_bad_ops) begin
            r_err   <= 1'b1;
            r_state <= LOAD_M;
          end else begin
            r_state <= START;
          end
        end
        START: begin
          r_wd    <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          // a result arriving on the last watchdog cycle still counts
          if (seq_done) begin
            r_c     <= seq_result;
            r_sel   <= 1'b1;
            r_state <= SHOW;
          end else if (r_wd == WD_LAST) begin
            r_err   <= 1'b1;
            r_state <= LOAD_M;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        SHOW: if (w_key_evt) begin
          r_sel   <= 1'b0;
          r_state <= LOAD_M;
        end
        default: r_state <= LOAD_M;
      endcase
    end
  end

  assign seq_m     = r_m;
  assign seq_e     = r_e;
  assign seq_n     = r_n;
  assign seq_c     = r_c;
  assign seq_sel   = r_sel;
  assign seq_err   = r_err;
  assign seq_start = (r_state == START);
  assign seq_state = r_state;

endmodule
